// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: answers a host start pulse with ACK and a 40-bit frame.
// Optional fault_inj input when DHT11_RESPONDER_FAULT_EN is defined.
module dht11_responder #(
   parameter int CLK_DIV     = 50,
   parameter int T_START_MIN = 18000,
   parameter int T_WAIT      = 30,
   parameter int T_ACK       = 80,
   parameter int T_BIT_LOW   = 50,
   parameter int T_ZERO      = 26,
   parameter int T_ONE       = 70
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   inout  wire         dht11,
`ifdef DHT11_RESPONDER_FAULT_EN
   input  logic        fault_inj,
`endif
   input  logic [31:0] data_in,
   output logic        busy,
   output logic        frame_done,
   output logic        err
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOST_LOW,
      S_WAIT,
      S_ACK_LOW,
      S_ACK_HIGH,
      S_BIT_LOW,
      S_BIT_HIGH,
      S_END_LOW
   } state_t;

   state_t      state, state_nx;
   logic        bus_s1, bus_s2, bus_s3;
   logic [DW-1:0] div_cnt;
   logic        tick;
   logic [14:0] cnt;
   logic [14:0] plen;
   logic [39:0] shreg;
   logic [5:0]  bit_idx;
   logic [7:0]  csum;
   logic        state_chg;
   logic        ph_done;
   logic        fall;
   logic        start_ok;
   logic        collide;
   logic        drive_low;

   // Synchroniser; third flop gives a falling-edge detect for start arming
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_s1 <= 1'b1;
         bus_s2 <= 1'b1;
         bus_s3 <= 1'b1;
      end else begin
         bus_s1 <= dht11;
         bus_s2 <= bus_s1;
         bus_s3 <= bus_s2;
      end
   end

   assign fall      = bus_s3 & ~bus_s2;
   assign tick      = (div_cnt == DW'(CLK_DIV - 1));
   assign state_chg = (state != state_nx);

   // Divider restarts on every phase entry so each phase is exactly N ticks
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (state_chg || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state_chg) begin
         cnt <= '0;
      end else if (tick && (cnt != 15'h7fff)) begin
         cnt <= cnt + 15'd1;
      end
   end

`ifdef DHT11_RESPONDER_FAULT_EN
   assign csum = (data_in[31:24] + data_in[23:16] + data_in[15:8]
                  + data_in[7:0]) ^ {7'd0, fault_inj};
`else
   assign csum = data_in[31:24] + data_in[23:16] + data_in[15:8]
                 + data_in[7:0];
`endif

   always_comb begin
      plen = 15'd1;
      unique case (state)
         S_WAIT:                plen = 15'(T_WAIT);
         S_ACK_LOW, S_ACK_HIGH: plen = 15'(T_ACK);
         S_BIT_LOW, S_END_LOW:  plen = 15'(T_BIT_LOW);
         S_BIT_HIGH:            plen = shreg[39] ? 15'(T_ONE)
                                                 : 15'(T_ZERO);
         default:               plen = 15'd1;
      endcase
   end

   assign ph_done  = tick && (cnt == plen - 15'd1);
   assign start_ok = (state == S_HOST_LOW) && bus_s2
                     && (cnt >= 15'(T_START_MIN));
   assign collide  = ((state == S_ACK_HIGH) || (state == S_BIT_HIGH))
                     && !bus_s2 && (cnt >= 15'd3);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_idx <= '0;
      end else if (start_ok) begin
         shreg   <= {data_in, csum};
         bit_idx <= '0;
      end else if ((state == S_BIT_HIGH) && ph_done && !collide) begin
         shreg   <= {shreg[38:0], 1'b0};
         bit_idx <= bit_idx + 6'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (fall) state_nx = S_HOST_LOW;
         S_HOST_LOW:
            if (bus_s2) state_nx = start_ok ? S_WAIT : S_IDLE;
         S_WAIT:
            if (ph_done) state_nx = S_ACK_LOW;
         S_ACK_LOW:
            if (ph_done) state_nx = S_ACK_HIGH;
         S_ACK_HIGH:
            if (collide)      state_nx = S_IDLE;
            else if (ph_done) state_nx = S_BIT_LOW;
         S_BIT_LOW:
            if (ph_done) state_nx = S_BIT_HIGH;
         S_BIT_HIGH:
            if (collide)      state_nx = S_IDLE;
            else if (ph_done) state_nx = (bit_idx == 6'd39) ? S_END_LOW
                                                            : S_BIT_LOW;
         S_END_LOW:
            if (ph_done) state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      drive_low  = (state == S_ACK_LOW) || (state == S_BIT_LOW)
                   || (state == S_END_LOW);
      busy       = (state != S_IDLE) && (state != S_HOST_LOW);
      frame_done = (state == S_END_LOW) && ph_done;
      err        = ((state == S_HOST_LOW) && bus_s2 && !start_ok)
                   || collide;
   end

   assign dht11 = drive_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder acting as a DHT11 host.
// Uses a short clock divider and start threshold to keep runs small.
module tb_dht11_responder;

   localparam int D     = 2;
   localparam int TSMIN = 60;
   localparam int TW    = 30;
   localparam int TA    = 80;
   localparam int TBL   = 50;
   localparam int T0    = 26;
   localparam int T1    = 70;
   localparam int TMO   = 20000;

   logic        sys_clk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        host_low = 1'b0;
   logic [31:0] data_in = '0;
`ifdef DHT11_RESPONDER_FAULT_EN
   logic        fault_inj = 1'b0;
`endif
   logic        busy, frame_done, err;
   wire         dht11;

   pullup (dht11);
   assign dht11 = host_low ? 1'b0 : 1'bz;

   dht11_responder #(
      .CLK_DIV(D), .T_START_MIN(TSMIN), .T_WAIT(TW), .T_ACK(TA),
      .T_BIT_LOW(TBL), .T_ZERO(T0), .T_ONE(T1)
   ) dut (
      .sys_clk(sys_clk),
      .rst_n(rst_n),
      .dht11(dht11),
`ifdef DHT11_RESPONDER_FAULT_EN
      .fault_inj(fault_inj),
`endif
      .data_in(data_in),
      .busy(busy),
      .frame_done(frame_done),
      .err(err)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;
   int err_cnt = 0;
   int busy_drop = 0;
   bit in_frame = 0;
   bit tmo_flag = 0;

   always @(negedge sys_clk) begin
      if (frame_done === 1'b1) fd_cnt++;
      if (err === 1'b1) err_cnt++;
      if (in_frame && busy !== 1'b1) busy_drop++;
   end

   // Reference: checksum is the byte sum mod 256, frame sent MSB first
   function automatic logic [39:0] model_frame(input logic [31:0] d,
                                               input bit f);
      int s;
      s = (int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8])
           + int'(d[7:0])) % 256;
      if (f) s = s ^ 1;
      return {d, s[7:0]};
   endfunction

   task automatic wait_level(input logic lvl, output int n);
      n = 0;
      if (tmo_flag) return;
      do begin
         n++;
         @(negedge sys_clk);
      end while (dht11 === lvl && n < TMO);
      if (n >= TMO) tmo_flag = 1;
   endtask

   task automatic host_start(input int low_us);
      @(negedge sys_clk);
      host_low = 1'b1;
      repeat (low_us * D) @(negedge sys_clk);
      host_low = 1'b0;
      @(negedge sys_clk);
   endtask

   task automatic rx_frame(output logic [39:0] w, output int wait_n,
                           output int acklo, output int ackhi,
                           output int endlo, output int bad);
      int lo, hi;
      w = '0;
      bad = 0;
      wait_level(1'b1, wait_n);
      data_in = $urandom;
      in_frame = 1;
      wait_level(1'b0, acklo);
      wait_level(1'b1, ackhi);
      for (int i = 0; i < 40; i++) begin
         wait_level(1'b0, lo);
         if (lo != TBL * D) bad++;
         wait_level(1'b1, hi);
         if (hi == T1 * D) begin
            w = {w[38:0], 1'b1};
         end else begin
            w = {w[38:0], 1'b0};
            if (hi != T0 * D) bad++;
         end
      end
      in_frame = 0;
      wait_level(1'b0, endlo);
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (dht11 !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0
          || err !== 1'b0) begin
         errors++;
         $display("FAIL reset: bus=%b busy=%b fd=%b err=%b, want 1 0 0 0",
                  dht11, busy, frame_done, err);
      end
      repeat (4) @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic test_frame(input logic [31:0] d, input bit f,
                             output logic [39:0] w);
      logic [39:0] exp;
      int wn, al, ah, el, bad, fd0, er0;
      exp = model_frame(d, f);
      data_in = d;
      fd0 = fd_cnt;
      er0 = err_cnt;
      busy_drop = 0;
      tmo_flag = 0;
      host_start(TSMIN + 20);
      rx_frame(w, wn, al, ah, el, bad);
      repeat (4) @(negedge sys_clk);
      checks++;
      if (tmo_flag || w !== exp) begin
         errors++;
         $display("FAIL frame_word: got %h want %h tmo=%0d", w, exp,
                  tmo_flag);
      end
      checks++;
      if (al != TA * D || ah != TA * D || el != TBL * D || bad != 0) begin
         errors++;
         $display("FAIL frame_timing: acklo=%0d ackhi=%0d endlo=%0d bad=%0d want %0d %0d %0d 0",
                  al, ah, el, bad, TA * D, TA * D, TBL * D);
      end
      checks++;
      if (wn < TW * D - 2 || wn > TW * D + 6) begin
         errors++;
         $display("FAIL wait_time: got %0d cycles want about %0d", wn,
                  TW * D);
      end
      checks++;
      if (fd_cnt - fd0 != 1 || err_cnt - er0 != 0 || busy_drop != 0
          || busy !== 1'b0) begin
         errors++;
         $display("FAIL frame_flags: fd=%0d err=%0d drops=%0d busy=%b want 1 0 0 0",
                  fd_cnt - fd0, err_cnt - er0, busy_drop, busy);
      end
   endtask

   task automatic test_spec_frame;
      logic [39:0] w;
      test_frame(32'h3700_1A05, 1'b0, w);
      checks++;
      if (w[7:0] !== 8'h56) begin
         errors++;
         $display("FAIL spec_checksum: got %h want 56", w[7:0]);
      end
   endtask

   task automatic test_wrap;
      logic [39:0] w;
      test_frame(32'hFFFF_FFFF, 1'b0, w);
      checks++;
      if (w[7:0] !== 8'hFC) begin
         errors++;
         $display("FAIL wrap_checksum: got %h want fc", w[7:0]);
      end
   endtask

   task automatic test_random;
      logic [39:0] w;
      for (int i = 0; i < 2; i++) test_frame($urandom, 1'b0, w);
   endtask

   task automatic test_short_start;
      int er0, drv, bsy;
      er0 = err_cnt;
      drv = 0;
      bsy = 0;
      host_start(30);
      repeat (400) begin
         @(negedge sys_clk);
         if (dht11 !== 1'b1) drv++;
         if (busy !== 1'b0) bsy++;
      end
      checks++;
      if (err_cnt - er0 != 1 || drv != 0 || bsy != 0) begin
         errors++;
         $display("FAIL short_start: err=%0d drv=%0d busy=%0d want 1 0 0",
                  err_cnt - er0, drv, bsy);
      end
   endtask

   task automatic test_collision;
      logic [39:0] w;
      int n, fd0, er0;
      data_in = 32'h3700_1A05;
      tmo_flag = 0;
      fd0 = fd_cnt;
      er0 = err_cnt;
      host_start(TSMIN + 20);
      wait_level(1'b1, n);
      wait_level(1'b0, n);
      wait_level(1'b1, n);
      for (int i = 0; i < 10; i++) begin
         wait_level(1'b0, n);
         wait_level(1'b1, n);
      end
      wait_level(1'b0, n);
      repeat (20 * D - 1) @(negedge sys_clk);
      host_low = 1'b1;
      repeat (10 * D) @(negedge sys_clk);
      host_low = 1'b0;
      repeat (20) @(negedge sys_clk);
      checks++;
      if (tmo_flag || err_cnt - er0 != 1 || fd_cnt - fd0 != 0
          || busy !== 1'b0 || dht11 !== 1'b1) begin
         errors++;
         $display("FAIL collision: err=%0d fd=%0d busy=%b bus=%b tmo=%0d want 1 0 0 1 0",
                  err_cnt - er0, fd_cnt - fd0, busy, dht11, tmo_flag);
      end
      test_frame($urandom, 1'b0, w);
   endtask

   task automatic test_reset_midframe;
      logic [39:0] w;
      int n, fd0, er0;
      data_in = $urandom;
      tmo_flag = 0;
      host_start(TSMIN + 20);
      wait_level(1'b1, n);
      repeat (10) @(negedge sys_clk);
      checks++;
      if (tmo_flag || dht11 !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ack_low_seen: bus=%b busy=%b want 0 1", dht11, busy);
      end
      fd0 = fd_cnt;
      er0 = err_cnt;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dht11 !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0
          || err !== 1'b0) begin
         errors++;
         $display("FAIL midframe_reset: bus=%b busy=%b fd=%b err=%b want 1 0 0 0",
                  dht11, busy, frame_done, err);
      end
      repeat (5) @(negedge sys_clk);
      rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      checks++;
      if (fd_cnt != fd0 || err_cnt != er0) begin
         errors++;
         $display("FAIL reset_pulses: fd=%0d err=%0d want 0 0",
                  fd_cnt - fd0, err_cnt - er0);
      end
      test_frame($urandom, 1'b0, w);
   endtask

`ifdef DHT11_RESPONDER_FAULT_EN
   task automatic test_fault;
      logic [39:0] w;
      fault_inj = 1'b1;
      test_frame(32'h3700_1A05, 1'b1, w);
      fault_inj = 1'b0;
      checks++;
      if (w[7:0] !== 8'h57) begin
         errors++;
         $display("FAIL fault_checksum: got %h want 57", w[7:0]);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_spec_frame;
      test_short_start;
      test_wrap;
      test_random;
      test_collision;
      test_reset_midframe;
`ifdef DHT11_RESPONDER_FAULT_EN
      test_fault;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
